// File: rtl/y86_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | y86_pkg : shared stat codes, icodes and control FSM states           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FROZEN = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/y86_hazard_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | y86_hazard_unit : combinational load/use, mispredict, ret, exception |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module y86_hazard_unit
    import y86_pkg::*;
#(
    parameter int RID_W = 4
) (
    input  logic [3:0]       i_D_icode,
    input  logic [3:0]       i_E_icode,
    input  logic [3:0]       i_M_icode,
    input  logic [RID_W-1:0] i_E_dstM,
    input  logic [RID_W-1:0] i_d_srcA,
    input  logic [RID_W-1:0] i_d_srcB,
    input  logic             i_e_Cnd,
    input  logic [1:0]       i_m_stat,
    input  logic [1:0]       i_W_stat,
    output logic             o_lu,
    output logic             o_mp,
    output logic             o_rt,
    output logic             o_ex,
    output logic             o_wfault
);

    localparam logic [RID_W-1:0] c_RNONE = {RID_W{1'b1}};

    logic w_is_load;

    assign w_is_load = (i_E_icode == I_MRMOVQ) || (i_E_icode == I_POPQ);
    assign o_lu      = w_is_load && (i_E_dstM != c_RNONE) &&
                       ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
    assign o_mp      = (i_E_icode == I_JXX) && !i_e_Cnd;
    assign o_rt      = (i_D_icode == I_RET) || (i_E_icode == I_RET) || (i_M_icode == I_RET);
    assign o_wfault  = (i_W_stat != STAT_AOK);
    assign o_ex      = (i_m_stat != STAT_AOK) || o_wfault;

endmodule : y86_hazard_unit
`default_nettype wire

// File: rtl/y86_pipe_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | y86_pipe_ctrl : pipeline stall/bubble control, halt/step FSM, perf   |
// | counters.  Rev 1.0                                                    |
// +-----------------------------------------------------------------------+
module y86_pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int RID_W   = 4,
    parameter int STEP_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [RID_W-1:0] E_dstM,
    input  logic [RID_W-1:0] d_srcA,
    input  logic [RID_W-1:0] d_srcB,
    input  logic             e_Cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             clr_cnt,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    logic w_lu, w_mp, w_rt, w_ex, w_wfault;
    logic w_step_mode, w_step_req;
    logic w_freeze, w_cnt_en;
    logic [3:0] w_inc;

    state_e           r_state;
    logic             r_halted;
    logic [CNT_W-1:0] r_cnt [4];

    y86_hazard_unit #(.RID_W(RID_W)) u_hazard (
        .i_D_icode (D_icode),
        .i_E_icode (E_icode),
        .i_M_icode (M_icode),
        .i_E_dstM  (E_dstM),
        .i_d_srcA  (d_srcA),
        .i_d_srcB  (d_srcB),
        .i_e_Cnd   (e_Cnd),
        .i_m_stat  (m_stat),
        .i_W_stat  (W_stat),
        .o_lu      (w_lu),
        .o_mp      (w_mp),
        .o_rt      (w_rt),
        .o_ex      (w_ex),
        .o_wfault  (w_wfault)
    );

    generate
        if (STEP_EN != 0) begin : g_step_on
            assign w_step_mode = step_mode;
            assign w_step_req  = step_req;
        end else begin : g_step_off
            assign w_step_mode = 1'b0;
            assign w_step_req  = 1'b0;
        end
    endgenerate

    assign w_freeze = (r_state == ST_FROZEN) || (r_state == ST_HALTED);
    assign w_cnt_en = (r_state == ST_RUN) || (r_state == ST_STEP);

    // D_stall masks D_bubble so a held D register is never also flushed.
    assign F_stall  = w_freeze || w_lu || w_rt;
    assign D_stall  = w_freeze || w_lu;
    assign D_bubble = !w_freeze && !w_lu && (w_mp || w_rt);
    assign E_bubble = w_freeze || w_mp || w_lu;
    assign M_bubble = w_freeze || w_ex;
    assign W_stall  = w_freeze || w_wfault;
    assign halted   = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wfault) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else if (w_step_mode) begin
                        r_state  <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (!w_step_mode)    r_state <= ST_RUN;
                    else if (w_step_req) r_state <= ST_STEP;
                end
                ST_STEP: begin
                    if (w_wfault) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else if (!w_step_mode) begin
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_FROZEN;
                    end
                end
                default: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign w_inc[0] = 1'b1;
    assign w_inc[1] = !w_wfault && !W_stall && (W_icode != I_NOP);
    assign w_inc[2] = w_lu;
    assign w_inc[3] = w_mp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (w_cnt_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_inc[i] && (r_cnt[i] != {CNT_W{1'b1}}))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    assign cyc_cnt = r_cnt[0];
    assign ret_cnt = r_cnt[1];
    assign lu_cnt  = r_cnt[2];
    assign mp_cnt  = r_cnt[3];

endmodule : y86_pipe_ctrl
`default_nettype wire

// File: tb/tb_y86_pipe_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_y86_pipe_ctrl : directed self-checking bench, 4-bit counters      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_y86_pipe_ctrl;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] D_icode, E_icode, M_icode, W_icode;
    logic [3:0] E_dstM, d_srcA, d_srcB;
    logic e_Cnd;
    logic [1:0] m_stat, W_stat;
    logic step_mode, step_req, clr_cnt;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    y86_pipe_ctrl #(.CNT_W(CNT_W), .RID_W(4), .STEP_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .step_mode(step_mode), .step_req(step_req), .clr_cnt(clr_cnt),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .halted(halted),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd = 1'b1; m_stat = 2'd0; W_stat = 2'd0;
    endtask

    task automatic chk_frozen(input string tag);
        chk({tag, "_F_stall"}, {31'b0, F_stall}, 32'd1);
        chk({tag, "_D_stall"}, {31'b0, D_stall}, 32'd1);
        chk({tag, "_D_bubble"}, {31'b0, D_bubble}, 32'd0);
        chk({tag, "_E_bubble"}, {31'b0, E_bubble}, 32'd1);
        chk({tag, "_M_bubble"}, {31'b0, M_bubble}, 32'd1);
        chk({tag, "_W_stall"}, {31'b0, W_stall}, 32'd1);
    endtask

    initial begin
        idle();
        step_mode = 1'b0; step_req = 1'b0; clr_cnt = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_cyc", {28'b0, cyc_cnt}, 32'd0);
        chk("rst_ret", {28'b0, ret_cnt}, 32'd0);
        chk("rst_F_stall", {31'b0, F_stall}, 32'd0);
        chk("rst_W_stall", {31'b0, W_stall}, 32'd0);
        rst_n = 1'b1;

        // mrmovq -> %rax consumed by addq in decode
        E_icode = 4'h5; E_dstM = 4'h0; d_srcA = 4'h0;
        #1;
        chk("lu_F_stall", {31'b0, F_stall}, 32'd1);
        chk("lu_D_stall", {31'b0, D_stall}, 32'd1);
        chk("lu_E_bubble", {31'b0, E_bubble}, 32'd1);
        chk("lu_D_bubble", {31'b0, D_bubble}, 32'd0);
        tick();
        chk("lu_cnt1", {28'b0, lu_cnt}, 32'd1);
        chk("lu_cyc1", {28'b0, cyc_cnt}, 32'd1);

        // jne not taken
        idle(); E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        chk("mp_D_bubble", {31'b0, D_bubble}, 32'd1);
        chk("mp_E_bubble", {31'b0, E_bubble}, 32'd1);
        chk("mp_F_stall", {31'b0, F_stall}, 32'd0);
        chk("mp_D_stall", {31'b0, D_stall}, 32'd0);
        tick();
        chk("mp_cnt1", {28'b0, mp_cnt}, 32'd1);
        chk("mp_lu_cnt", {28'b0, lu_cnt}, 32'd1);

        // ret in D with a load/use in E
        idle(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        #1;
        chk("rtlu_D_stall", {31'b0, D_stall}, 32'd1);
        chk("rtlu_D_bubble", {31'b0, D_bubble}, 32'd0);
        chk("rtlu_F_stall", {31'b0, F_stall}, 32'd1);
        tick();
        chk("rtlu_lu_cnt", {28'b0, lu_cnt}, 32'd2);
        chk("rtlu_cyc", {28'b0, cyc_cnt}, 32'd3);

        // ret alone in M: fetch stalls, decode bubbles
        idle(); M_icode = 4'h9;
        #1;
        chk("rt_F_stall", {31'b0, F_stall}, 32'd1);
        chk("rt_D_bubble", {31'b0, D_bubble}, 32'd1);
        chk("rt_E_bubble", {31'b0, E_bubble}, 32'd0);

        // load with RNONE destination is not a hazard; popq is
        idle(); E_icode = 4'h5;
        #1;
        chk("rnone_D_stall", {31'b0, D_stall}, 32'd0);
        idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        #1;
        chk("popq_D_stall", {31'b0, D_stall}, 32'd1);
        idle(); m_stat = 2'd3;
        #1;
        chk("mstat_M_bubble", {31'b0, M_bubble}, 32'd1);
        chk("mstat_W_stall", {31'b0, W_stall}, 32'd0);

        // saturation: 20 retiring cycles on 4-bit counters
        idle(); W_icode = 4'h6;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_ret", {28'b0, ret_cnt}, 32'hF);
        chk("sat_cyc", {28'b0, cyc_cnt}, 32'hF);
        chk("sat_lu", {28'b0, lu_cnt}, 32'd2);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_ret", {28'b0, ret_cnt}, 32'd0);
        chk("clr_cyc", {28'b0, cyc_cnt}, 32'd0);
        chk("clr_mp", {28'b0, mp_cnt}, 32'd0);
        W_icode = 4'h1;

        // single-step
        step_mode = 1'b1;
        tick();
        chk("frz_cyc", {28'b0, cyc_cnt}, 32'd1);
        chk_frozen("frz");
        for (int i = 0; i < 3; i++) tick();
        chk("frz_cyc_hold", {28'b0, cyc_cnt}, 32'd1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_F_stall", {31'b0, F_stall}, 32'd0);
        chk("step_E_bubble", {31'b0, E_bubble}, 32'd0);
        tick();
        chk("step1_cyc", {28'b0, cyc_cnt}, 32'd2);
        chk("step1_refrz", {31'b0, F_stall}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk("step2_cyc", {28'b0, cyc_cnt}, 32'd3);
        chk_frozen("step2");

        // reset asserted mid-STEP
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid_cyc", {28'b0, cyc_cnt}, 32'd0);
        chk("rstmid_F_stall", {31'b0, F_stall}, 32'd0);
        chk("rstmid_halted", {31'b0, halted}, 32'd0);
        step_mode = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("rstmid_run_cyc", {28'b0, cyc_cnt}, 32'd1);

        // W-stage address fault -> halt
        W_stat = 2'd2;
        #1;
        chk("adr_W_stall", {31'b0, W_stall}, 32'd1);
        chk("adr_M_bubble", {31'b0, M_bubble}, 32'd1);
        chk("adr_halted0", {31'b0, halted}, 32'd0);
        tick();
        chk("adr_halted1", {31'b0, halted}, 32'd1);
        chk("adr_cyc", {28'b0, cyc_cnt}, 32'd2);
        W_stat = 2'd0; W_icode = 4'h6;
        tick();
        tick();
        chk("hlt_stays", {31'b0, halted}, 32'd1);
        chk("hlt_cyc_frozen", {28'b0, cyc_cnt}, 32'd2);
        chk("hlt_ret_frozen", {28'b0, ret_cnt}, 32'd0);
        chk_frozen("hlt");
        rst_n = 1'b0;
        #1;
        chk("hlt_rst", {31'b0, halted}, 32'd0);
        chk("hlt_rst_cyc", {28'b0, cyc_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_y86_pipe_ctrl
`default_nettype wire
